// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and sizing helpers for the truth-table sweeper
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int N_IN_MAX = 6;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sweep_dwell_timer.sv
// sweep_dwell_timer: counts DWELL cycles per vector, pulses expire on the last one and reloads
module sweep_dwell_timer
    import sweep_pkg::*;
#(
    parameter int DWELL = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        expire = enable && (cnt_q == CW'(DWELL - 1));
        cnt_d  = clear ? '0 : expire ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 2^N_IN vectors, samples the function output and checks it against a minterm mask
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int DWELL = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [(1<<N_IN)-1:0] expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [(1<<N_IN)-1:0] captured,
    output logic [N_IN:0]        mismatch_count,
    output logic [N_IN-1:0]      first_fail_idx
);
    localparam int V = 1 << N_IN;
    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d, ff_q, ff_d;
    logic [V-1:0]    exp_q, exp_d, cap_q, cap_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            pass_q, pass_d, start_ok, expire, tmr_en;
    sweep_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_ok),
        .enable (tmr_en),
        .expire (expire)
    );
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        exp_d    = exp_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        start_ok = start && (state_q != RUN);
        tmr_en   = (state_q == RUN) && !abort;
        if (start_ok) begin
            state_d = RUN;
            vec_d   = '0;
            exp_d   = expected;
            cap_d   = '0;
            cnt_d   = '0;
            ff_d    = '0;
            pass_d  = 1'b0;
        end else if (state_q == RUN) begin
            if (abort) begin
                state_d = IDLE;
                vec_d   = '0;
                pass_d  = 1'b0;
            end else if (expire) begin
                cap_d[vec_q] = dut_out;
                if (dut_out != exp_q[vec_q]) begin
                    cnt_d = cnt_q + 1'b1;
                    ff_d  = (cnt_q == '0) ? vec_q : ff_q;
                end
                // vec wraps to 0 after the last vector, which is the idle drive value
                vec_d = vec_q + 1'b1;
                if (vec_q == '1) begin
                    state_d = DONE;
                    pass_d  = (cap_d == exp_q);
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end
    assign vec_out        = vec_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign captured       = cap_q;
    assign mismatch_count = cnt_q;
    assign first_fail_idx = ff_q;
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-running, synthesizable exhaustive-stimulus engine for an N-input, 1-output combinational function under test.
- Drives all 2^N input vectors in ascending binary order and holds each for a programmable dwell time.
- Samples the function output at the end of each dwell and compares the captured truth table against an expected minterm mask.
- Sits beside the per-problem combinational blocks; replaces hand-written exhaustive stimulus sequences with one reusable checker.

Parameters:
- N_IN, 4, number of function inputs; legal range 1..6.
- DWELL, 20, clock cycles each vector is held; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; accepted only in IDLE or DONE.
- abort  input  1  synchronous abort of a running sweep.
- expected  input  2^N_IN  expected output; bit i is the value for input vector i.
- dut_out  input  1  output of the function under test.
- vec_out  output  N_IN  stimulus vector; MSB drives the first function input (A).
- busy  output  1  high while sweeping.
- done  output  1  high from sweep completion until the next start or reset.
- pass  output  1  valid while done; 1 if captured equals the latched expected value.
- captured  output  2^N_IN  sampled truth table.
- mismatch_count  output  N_IN+1  number of vectors that mismatched.
- first_fail_idx  output  N_IN  lowest mismatching vector index; 0 if none.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - vec_out, busy, done, pass, captured, mismatch_count, first_fail_idx, dwell counter and latched expected all 0.
- State IDLE: vec_out=0. When start=1 at edge k:
  - state becomes RUN, busy=1.
  - vec=0, dwell counter=0.
  - expected is latched into exp_q.
  - captured, mismatch_count and first_fail_idx are cleared; done=0, pass=0.
- State RUN, each edge:
  - If dwell counter < DWELL-1, increment it.
  - If dwell counter == DWELL-1, sample: captured[vec] <= dut_out.
    - If dut_out != exp_q[vec], increment mismatch_count; on the first mismatch of the sweep, first_fail_idx <= vec.
    - If vec == 2^N_IN-1: state becomes DONE, busy=0, done=1, and pass is set from the final comparison, including the last sample.
    - Otherwise: vec increments and the dwell counter returns to 0.
- Timing:
  - Each vector is driven for exactly DWELL cycles.
  - done rises at edge k + 2^N_IN*DWELL.
  - With DWELL=1, the sample is taken on every edge.
- State DONE:
  - vec_out=0; outputs hold their values.
  - start=1 restarts the sweep exactly as from IDLE (results are cleared).
- abort=1 in RUN:
  - Next state is IDLE; busy=0, done=0, pass=0, vec_out=0.
  - captured and counters keep their partial values until the next start.
  - abort has priority over a same-cycle sample.
- start while in RUN is ignored. abort in IDLE or DONE is ignored.
- Simultaneous start and abort in DONE: start wins.
- Changes to expected after start have no effect until the next start.
- mismatch_count saturates naturally: its maximum value 2^N_IN fits in N_IN+1 bits.
- Reset asserted mid-sweep: all outputs return to reset values immediately; no partial results are retained.

Decomposition:
- Shared package `sweep_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - clog2 function.
  - N_IN_MAX=6 constant.
- One sub-module: `sweep_dwell_timer`.
  - Parametrised by DWELL.
  - Inputs clk, rst_n, clear, enable; output `expire`, a one-cycle pulse when the count reaches DWELL-1.
  - Auto-reloads on expire.
- The top-level module holds the FSM, the vector counter and the capture/compare logic.

Test Plan:
1. Good DUT: N_IN=4, DWELL=20, dut_out = 4-input parity of vec_out, expected=16'h6996, start at cycle 10 → busy for 320 cycles; done at cycle 330; pass=1; captured=16'h6996; mismatch_count=0; first_fail_idx=0; every vec_out value held exactly 20 cycles.
2. Faulty DUT: same setup, but the DUT output is forced to 1 at vector 5 → captured=16'h69B6, mismatch_count=1, first_fail_idx=5, pass=0.
3. Multiple faults: DUT output inverted at vectors 3, 9 and 15 → mismatch_count=3, first_fail_idx=3, pass=0; then restart from DONE with a correct DUT → pass=1 and all counters cleared.
4. Abort: abort pulsed during vector 7 → next cycle busy=0, done=0, vec_out=0; a further start while in RUN (on a separate run) is ignored, with no change to vec_out timing.
5. Reset mid-sweep: rst_n driven low during vector 10 → all outputs are 0 within the same cycle, independent of clk; after release, state is IDLE and vec_out=0.
6. Corner configuration: N_IN=2, DWELL=1, dut_out = AND of both inputs, expected=4'b1000 → done 4 cycles after start, pass=1, captured=4'b1000.
